// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the RV32I hazard / forwarding controller.
//   fwd_sel_e   : EX operand mux select, ordered to match the Mux3 a/b/c inputs
//   ex_stage_t  : shadow of the instruction currently in EX
//   mem_stage_t : shadow of the instruction currently in MEM
//   wb_stage_t  : shadow of the instruction currently in WB
//   REG_ZERO    : x0, which is hard-wired to zero and never forwarded
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_ADDR_W_PKG = 5;

  typedef logic [REG_ADDR_W_PKG-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic      valid;
    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      uses_rs1;
    logic      uses_rs2;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
  } ex_stage_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
  } mem_stage_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      reg_write;
  } wb_stage_t;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel_gen.sv
// -----------------------------------------------------------------------------
// fwd_sel_gen
// Combinational forwarding select for one EX-stage source operand.
// Ports:
//   i_ex_valid                          : EX holds a real instruction
//   i_rs, i_uses_rs                     : operand source register and whether it is read
//   i_mem_valid/i_mem_reg_write/i_mem_rd: producer currently in MEM
//   i_wb_valid/i_wb_reg_write/i_wb_rd   : producer currently in WB
//   o_sel                               : FWD_MEM, FWD_WB or FWD_REG
// -----------------------------------------------------------------------------
module fwd_sel_gen
  import hazard_pkg::*;
(
  input  logic      i_ex_valid,
  input  reg_addr_t i_rs,
  input  logic      i_uses_rs,
  input  logic      i_mem_valid,
  input  logic      i_mem_reg_write,
  input  reg_addr_t i_mem_rd,
  input  logic      i_wb_valid,
  input  logic      i_wb_reg_write,
  input  reg_addr_t i_wb_rd,
  output fwd_sel_e  o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // x0 is excluded so a write to x0 never shadows the real register file value
  assign w_mem_hit = i_mem_valid & i_mem_reg_write & (i_mem_rd != REG_ZERO) & (i_mem_rd == i_rs);
  assign w_wb_hit  = i_wb_valid  & i_wb_reg_write  & (i_wb_rd  != REG_ZERO) & (i_wb_rd  == i_rs);

  // MEM holds the younger producer, so it wins over WB
  always_comb begin
    o_sel = FWD_REG;
    if (i_ex_valid && i_uses_rs) begin
      if (w_mem_hit) begin
        o_sel = FWD_MEM;
      end else if (w_wb_hit) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
// Hazard and forwarding controller for the 5-stage RV32I pipeline. Keeps its own
// shadow of the EX/MEM/WB destination info, drives the EX operand forwarding
// selects, the load-use stall and the branch/load-use flushes, and counts
// load-use stalls and branch flushes in saturating counters.
// Ports:
//   i_clk, i_rst              : clock (rising edge), async active-high reset
//   i_hold                    : global freeze, shadow state and counters hold
//   i_id_*                    : decode-stage instruction info
//   i_ex_branch_taken         : EX redirect (taken branch / jump)
//   o_fwd_a_sel, o_fwd_b_sel  : EX operand mux selects (00 RF, 01 WB, 10 MEM)
//   o_stall_f, o_stall_d      : hold PC / IF-ID register
//   o_flush_d, o_flush_e      : bubble IF-ID / ID-EX register
//   o_load_use_cnt, o_flush_cnt: performance counters
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_PKG,
  parameter int CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_hold,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_uses_rs1,
  input  logic                  i_id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_reg_write,
  input  logic                  i_id_mem_read,
  input  logic                  i_ex_branch_taken,
  output logic [1:0]            o_fwd_a_sel,
  output logic [1:0]            o_fwd_b_sel,
  output logic                  o_stall_f,
  output logic                  o_stall_d,
  output logic                  o_flush_d,
  output logic                  o_flush_e,
  output logic [CNT_W-1:0]      o_load_use_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ex_stage_t        r_ex;
  mem_stage_t       r_mem;
  wb_stage_t        r_wb;
  ex_stage_t        w_ex_next;
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_lu;
  fwd_sel_e         w_fwd_a;
  fwd_sel_e         w_fwd_b;
  logic             w_unused;

  // The load type of the MEM occupant only matters while it sits in EX
  assign w_unused = r_mem.mem_read;

  fwd_sel_gen u_fwd_a (
    .i_ex_valid      (r_ex.valid),
    .i_rs            (r_ex.rs1),
    .i_uses_rs       (r_ex.uses_rs1),
    .i_mem_valid     (r_mem.valid),
    .i_mem_reg_write (r_mem.reg_write),
    .i_mem_rd        (r_mem.rd),
    .i_wb_valid      (r_wb.valid),
    .i_wb_reg_write  (r_wb.reg_write),
    .i_wb_rd         (r_wb.rd),
    .o_sel           (w_fwd_a)
  );

  fwd_sel_gen u_fwd_b (
    .i_ex_valid      (r_ex.valid),
    .i_rs            (r_ex.rs2),
    .i_uses_rs       (r_ex.uses_rs2),
    .i_mem_valid     (r_mem.valid),
    .i_mem_reg_write (r_mem.reg_write),
    .i_mem_rd        (r_mem.rd),
    .i_wb_valid      (r_wb.valid),
    .i_wb_reg_write  (r_wb.reg_write),
    .i_wb_rd         (r_wb.rd),
    .o_sel           (w_fwd_b)
  );

  assign o_fwd_a_sel = w_fwd_a;
  assign o_fwd_b_sel = w_fwd_b;

  // A load in EX cannot feed the instruction in ID in time; the loaded value
  // only exists once the load leaves MEM, so one bubble is required
  assign w_lu = i_id_valid & r_ex.valid & r_ex.mem_read & r_ex.reg_write &
                (r_ex.rd != REG_ZERO) &
                ((i_id_uses_rs1 & (i_id_rs1 == r_ex.rd)) |
                 (i_id_uses_rs2 & (i_id_rs2 == r_ex.rd)));

  // A taken branch kills the dependent instruction anyway, so it overrides the stall
  assign o_stall_f = w_lu & ~i_ex_branch_taken & ~i_hold;
  assign o_stall_d = w_lu & ~i_ex_branch_taken & ~i_hold;
  assign o_flush_e = (w_lu | i_ex_branch_taken) & ~i_hold;
  assign o_flush_d = i_ex_branch_taken & ~i_hold;

  // Next EX shadow content: a bubble on flush, otherwise whatever decode presents
  always_comb begin
    w_ex_next = '0;
    if (!o_flush_e) begin
      w_ex_next.valid     = i_id_valid;
      w_ex_next.rs1       = i_id_rs1;
      w_ex_next.rs2       = i_id_rs2;
      w_ex_next.uses_rs1  = i_id_uses_rs1;
      w_ex_next.uses_rs2  = i_id_uses_rs2;
      w_ex_next.rd        = i_id_rd;
      w_ex_next.reg_write = i_id_reg_write;
      w_ex_next.mem_read  = i_id_mem_read;
    end
  end

  // Shadow pipeline advances in lock-step with the real pipeline
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!i_hold) begin
      r_ex            <= w_ex_next;
      r_mem.valid     <= r_ex.valid;
      r_mem.rd        <= r_ex.rd;
      r_mem.reg_write <= r_ex.reg_write;
      r_mem.mem_read  <= r_ex.mem_read;
      r_wb.valid      <= r_mem.valid;
      r_wb.rd         <= r_mem.rd;
      r_wb.reg_write  <= r_mem.reg_write;
    end
  end

  // Saturating performance counters, frozen together with the pipeline
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lu_cnt    <= '0;
      r_flush_cnt <= '0;
    end else if (!i_hold) begin
      if (o_stall_d && (r_lu_cnt != '1)) begin
        r_lu_cnt <= r_lu_cnt + CNT_ONE;
      end
      if (o_flush_d && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign o_load_use_cnt = r_lu_cnt;
  assign o_flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
// Directed program fragments followed by random instruction streams, checked
// against a behavioural model of the pipeline kept as a three-entry array of
// in-flight instructions (EX, MEM, WB). Counters use a narrow width so that
// saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clock;
  logic          rst;
  logic          hold;
  logic          idValid;
  logic [4:0]    idRs1;
  logic [4:0]    idRs2;
  logic          idUsesRs1;
  logic          idUsesRs2;
  logic [4:0]    idRd;
  logic          idRegWrite;
  logic          idMemRead;
  logic          branchTaken;
  logic [1:0]    fwdASel;
  logic [1:0]    fwdBSel;
  logic          stallF;
  logic          stallD;
  logic          flushD;
  logic          flushE;
  logic [CW-1:0] luCnt;
  logic [CW-1:0] flCnt;

  int vecCount  = 0;
  int missCount = 0;

  hazard_fwd_ctrl #(.REG_ADDR_W(5), .CNT_W(CW)) dut (
    .i_clk             (clock),
    .i_rst             (rst),
    .i_hold            (hold),
    .i_id_valid        (idValid),
    .i_id_rs1          (idRs1),
    .i_id_rs2          (idRs2),
    .i_id_uses_rs1     (idUsesRs1),
    .i_id_uses_rs2     (idUsesRs2),
    .i_id_rd           (idRd),
    .i_id_reg_write    (idRegWrite),
    .i_id_mem_read     (idMemRead),
    .i_ex_branch_taken (branchTaken),
    .o_fwd_a_sel       (fwdASel),
    .o_fwd_b_sel       (fwdBSel),
    .o_stall_f         (stallF),
    .o_stall_d         (stallD),
    .o_flush_d         (flushD),
    .o_flush_e         (flushE),
    .o_load_use_cnt    (luCnt),
    .o_flush_cnt       (flCnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // In-flight instruction as the model sees it; index 0 = EX, 1 = MEM, 2 = WB
  typedef struct {
    bit v;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
    int rd;
    bit rw;
    bit mr;
  } instr_t;

  instr_t pipe [3];
  int     modelLu;
  int     modelFl;

  function automatic bit producesReg(instr_t p, int r);
    return p.v && p.rw && (p.rd != 0) && (p.rd == r);
  endfunction

  // The nearest older producer of the register supplies the value
  function automatic int expFwd(int r, bit uses);
    if (!pipe[0].v || !uses) return 0;
    if (producesReg(pipe[1], r)) return 2;
    if (producesReg(pipe[2], r)) return 1;
    return 0;
  endfunction

  function automatic bit modelLoadUse();
    if (!idValid || !pipe[0].v || !pipe[0].mr || !pipe[0].rw || pipe[0].rd == 0) return 0;
    return (idUsesRs1 && int'(idRs1) == pipe[0].rd) || (idUsesRs2 && int'(idRs2) == pipe[0].rd);
  endfunction

  function automatic bit expStall();
    return modelLoadUse() && !branchTaken && !hold;
  endfunction

  function automatic bit expFlushE();
    return (modelLoadUse() || branchTaken) && !hold;
  endfunction

  function automatic bit expFlushD();
    return branchTaken && !hold;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    modelLu = 0;
    modelFl = 0;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("fwd_a_sel", 32'(fwdASel), 32'(expFwd(pipe[0].rs1, pipe[0].u1)));
    checkValue("fwd_b_sel", 32'(fwdBSel), 32'(expFwd(pipe[0].rs2, pipe[0].u2)));
    checkValue("stall_f", 32'(stallF), 32'(expStall()));
    checkValue("stall_d", 32'(stallD), 32'(expStall()));
    checkValue("flush_d", 32'(flushD), 32'(expFlushD()));
    checkValue("flush_e", 32'(flushE), 32'(expFlushE()));
    checkValue("load_use_cnt", 32'(luCnt), 32'(modelLu));
    checkValue("flush_cnt", 32'(flCnt), 32'(modelFl));
  endtask

  // Drive one decode-stage instruction and check the outputs mid-cycle
  task automatic applyStimulus(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                               input int rd, input bit rw, input bit mr, input bit br, input bit hd);
    idValid     = v;
    idRs1       = 5'(rs1);
    idUsesRs1   = u1;
    idRs2       = 5'(rs2);
    idUsesRs2   = u2;
    idRd        = 5'(rd);
    idRegWrite  = rw;
    idMemRead   = mr;
    branchTaken = br;
    hold        = hd;
    vecCount++;
    @(negedge clock);
    checkOutput();
  endtask

  // Rising edge: the model advances exactly as the pipeline rules describe
  task automatic tick();
    bit     fe;
    bit     st;
    bit     fd;
    instr_t nxt;
    fe = expFlushE();
    st = expStall();
    fd = expFlushD();
    nxt.v   = idValid && !fe;
    nxt.rs1 = int'(idRs1);
    nxt.rs2 = int'(idRs2);
    nxt.u1  = idUsesRs1;
    nxt.u2  = idUsesRs2;
    nxt.rd  = int'(idRd);
    nxt.rw  = idRegWrite;
    nxt.mr  = idMemRead;
    @(posedge clock);
    if (!hold) begin
      if (st && modelLu < CNTMAX) modelLu++;
      if (fd && modelFl < CNTMAX) modelFl++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nxt;
    end
    #1;
  endtask

  task automatic alu(input int rd, input int rs1, input int rs2);
    applyStimulus(1, rs1, 1, rs2, 1, rd, 1, 0, 0, 0);
  endtask

  task automatic load(input int rd, input int rs1);
    applyStimulus(1, rs1, 1, 0, 0, rd, 1, 1, 0, 0);
  endtask

  task automatic nop();
    applyStimulus(1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    modelReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    tick();

    // add x5 ; add x6,x5,x1 back to back
    alu(5, 1, 2);  tick();
    alu(6, 5, 1);  tick();
    nop();
    checkValue("b2b_fwd_a", 32'(fwdASel), 32'h2);
    checkValue("b2b_fwd_b", 32'(fwdBSel), 32'h0);
    checkValue("b2b_stall", 32'(stallD), 32'h0);
    tick();

    // add x5 ; nop ; sub x7,x1,x5
    alu(5, 1, 2);  tick();
    nop();         tick();
    alu(7, 1, 5);  tick();
    nop();
    checkValue("wb_fwd_b", 32'(fwdBSel), 32'h1);
    tick();

    // two writers of x5 in MEM and WB
    alu(5, 1, 2);  tick();
    alu(5, 3, 4);  tick();
    alu(7, 1, 5);  tick();
    nop();
    checkValue("mem_prio_fwd_b", 32'(fwdBSel), 32'h2);
    tick();

    // lw x6 ; add x7,x6,x6
    load(6, 1);    tick();
    alu(7, 6, 6);
    checkValue("lu_stall_f", 32'(stallF), 32'h1);
    checkValue("lu_flush_e", 32'(flushE), 32'h1);
    tick();
    alu(7, 6, 6);
    checkValue("lu_once", 32'(stallD), 32'h0);
    tick();
    nop();
    checkValue("lu_fwd_a", 32'(fwdASel), 32'h1);
    checkValue("lu_fwd_b", 32'(fwdBSel), 32'h1);
    checkValue("lu_cnt1", 32'(luCnt), 32'h1);
    tick();

    // load to x0 never stalls or forwards
    load(0, 1);    tick();
    alu(7, 0, 0);
    checkValue("x0_no_stall", 32'(stallD), 32'h0);
    tick();
    nop();
    checkValue("x0_fwd_a", 32'(fwdASel), 32'h0);
    tick();

    // load-use coinciding with a taken branch
    load(6, 1);    tick();
    applyStimulus(1, 6, 1, 6, 1, 7, 1, 0, 1, 0);
    checkValue("br_flush_d", 32'(flushD), 32'h1);
    checkValue("br_no_stall", 32'(stallF), 32'h0);
    tick();
    nop();
    checkValue("br_flush_cnt", 32'(flCnt), 32'h1);
    checkValue("br_lu_cnt", 32'(luCnt), 32'h1);
    tick();

    // hold for three cycles while a load-use is pending
    load(6, 1);    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 6, 1, 6, 1, 7, 1, 0, 0, 1);
      checkValue("hold_no_stall", 32'(stallD), 32'h0);
      tick();
    end
    alu(7, 6, 6);
    checkValue("post_hold_stall", 32'(stallD), 32'h1);
    tick();
    alu(7, 6, 6);  tick();
    nop();
    checkValue("post_hold_cnt", 32'(luCnt), 32'h2);
    tick();

    // asynchronous reset in the middle of a stall
    load(6, 1);    tick();
    alu(7, 6, 6);
    #1 rst = 1'b1;
    #1;
    modelReset();
    checkValue("rst_stall", 32'(stallD), 32'h0);
    checkValue("rst_flush_e", 32'(flushE), 32'h0);
    checkValue("rst_lu_cnt", 32'(luCnt), 32'h0);
    checkOutput();
    @(posedge clock);
    #1 rst = 1'b0;

    // long run of load-use stalls drives the counter into saturation
    for (int i = 0; i < 20; i++) begin
      load(6, 1);    tick();
      alu(7, 6, 6);  tick();
    end
    nop();
    checkValue("lu_saturated", 32'(luCnt), 32'(CNTMAX));
    tick();

    // random instruction streams over a small register set
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 9) != 0), int'($urandom_range(0, 3)), 1'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RV32I pipeline.
- Tracks destination-register info of the instructions in EX, MEM and WB in its own shadow pipeline.
- Drives the selects of the two EX-stage operand 3:1 muxes, and the fetch/decode stall and decode/execute flush controls.
- Keeps saturating counters of load-use stalls and branch flushes for performance debug.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- hold  in  1  global pipeline freeze (e.g. memory busy).
- id_valid  in  1  decode stage holds a real instruction.
- id_rs1, id_rs2  in  REG_ADDR_W  decode source registers.
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1 / rs2.
- id_rd  in  REG_ADDR_W  decode destination register.
- id_reg_write  in  1  decode instruction writes rd.
- id_mem_read  in  1  decode instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump (redirect).
- fwd_a_sel, fwd_b_sel  out  2  EX operand mux selects: 00 register file, 01 WB result, 10 MEM result.
- stall_f, stall_d  out  1  hold PC / IF-ID register.
- flush_d, flush_e  out  1  clear IF-ID / ID-EX register (bubble).
- load_use_cnt, flush_cnt  out  CNT_W  performance counters.

Behaviour:
- Shadow stages:
  - EX: {valid, rs1, rs2, uses_rs1, uses_rs2, rd, reg_write, mem_read}.
  - MEM: {valid, rd, reg_write, mem_read}.
  - WB: {valid, rd, reg_write}.
- Reset (async, any time including mid-stall): all shadow valid bits 0, counters 0.
  - Outputs at reset: fwd selects 00, stall_f/stall_d/flush_d/flush_e 0.
- Forwarding (combinational from EX shadow state, 0-cycle latency), per operand A (rs1) and B (rs2):
  - 10 if MEM.valid & MEM.reg_write & MEM.rd != 0 & MEM.rd == EX.rsX & EX.uses_rsX.
  - else 01 if the same condition holds for WB.
  - else 00.
  - MEM has priority over WB (most recent producer).
  - rd == 0 is never forwarded.
  - EX.valid = 0 forces 00.
- The register file bypasses same-cycle WB write to ID read internally; this block does not cover the WB→ID case.
- Load-use hazard: lu = id_valid & EX.valid & EX.mem_read & EX.reg_write & EX.rd != 0 & ((id_uses_rs1 & id_rs1 == EX.rd) | (id_uses_rs2 & id_rs2 == EX.rd)).
- Control outputs:
  - stall_f = stall_d = lu & ~ex_branch_taken & ~hold.
  - flush_e = (lu | ex_branch_taken) & ~hold.
  - flush_d = ex_branch_taken & ~hold.
- Simultaneous branch and load-use: branch wins. No stall, both flushes asserted; lu_cnt unchanged, flush_cnt +1.
- Clock edge with hold = 1: all shadow stages and counters frozen; the external pipeline freezes on hold directly.
- Clock edge with hold = 0:
  - EX ← bubble (valid 0) if flush_e, else ID inputs with valid = id_valid.
  - MEM ← EX.
  - WB ← MEM.
- A load-use stall lasts exactly one cycle. The load then sits in MEM, so the dependent instruction forwards via 01 after the load reaches WB. It never forwards from MEM with mem_read set, because the bubble separates them.
- Counters: load_use_cnt +1 per non-hold cycle with stall_d; flush_cnt +1 per non-hold cycle with flush_d. Both saturate at all-ones; no wrap.
- No X propagation: with valid bits 0, the stored fields are don't-care and must not affect outputs.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_e enum {FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10}, matching the Mux3 a/b/c input order.
  - Packed structs ex_stage_t, mem_stage_t, wb_stage_t.
  - REG_ZERO constant.
- One sub-module, fwd_sel_gen: combinational comparator producing a fwd_sel_e for one operand. Instantiated twice (A, B).

Test Plan:
- add x5; add x6,x5,x1 back-to-back → in the second instruction's EX cycle fwd_a_sel = 10, fwd_b_sel = 00, no stall.
- add x5; nop; sub x7,x1,x5 → fwd_b_sel = 01. With both MEM and WB writing x5 → fwd_b_sel = 10.
- lw x6; add x7,x6,x6 → one cycle of stall_f = stall_d = flush_e = 1, then fwd_a_sel = fwd_b_sel = 01, load_use_cnt = 1. Same sequence with rd = x0 → no stall, selects 00.
- lw x6; add x7,x6 with ex_branch_taken = 1 in the same cycle → flush_d = flush_e = 1, stall = 0, flush_cnt +1, load_use_cnt unchanged.
- hold = 1 for 3 cycles during a pending load-use → stall/flush outputs 0, counters and shadow frozen. After release, the stall occurs exactly once.
- rst pulsed asynchronously mid-stall → all outputs 0 immediately. Counter preloaded near max via a long stall sequence → saturates at 2^CNT_W−1, no wrap.
